counter_sched: RTL and testbench

COUNTER_SCHED -- requirements
Module: counter_sched

---
 rtl/counter_sched_pkg.sv | 42 ++++
 rtl/counter_sched_rr_arbiter.sv | 49 ++++
 rtl/counter_sched.sv | 205 ++++++++++++++++++++
 tb/tb_counter_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// ---------------------------------------------------------------------------
// counter_sched_pkg
//   Shared definitions for the counter scheduler: FSM state encoding,
//   default geometry, the latched-command record and a small round-robin
//   helper.
//
//   The command record is sized for the widest supported counter (CMD_W).
//   Narrower instances zero-extend into it and truncate out of it, so one
//   package serves every WIDTH without parameterised types.
//
//   Optional feature macro (consumed by counter_sched):
//     COUNTER_SCHED_STOP_ON_ZERO_EN
// ---------------------------------------------------------------------------
package counter_sched_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;

  // Widest counter the command record can hold.
  localparam int CMD_W = 32;

  // Explicit encoding keeps the state register a plain 2-bit vector.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Command captured from the granted requester when it wins arbitration.
  typedef struct packed {
    logic             dir;    // 1 = count up, 0 = count down
    logic [CMD_W-1:0] val;    // counter load value
    logic [CMD_W-1:0] steps;  // number of ce cycles to issue
  } cmd_t;

  // Index following idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin selector. The search starts at index ptr and
//   moves upward, wrapping past NREQ-1 back to 0. The first requesting index
//   found wins.
//
// Ports
//   req  in  NREQ  request vector
//   ptr  in  IDXW  first index to consider
//   gnt  out NREQ  one-hot grant (all zero when no request)
//   idx  out IDXW  binary index of the granted requester
//   vld  out 1     some requester was granted
// ---------------------------------------------------------------------------
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx,
  output logic            vld
);

  // Two passes implement the wrap without modulo arithmetic: first the
  // indices at or above the pointer, then everything from 0 upward.
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!vld && req[i] && (i >= int'(ptr))) begin
        vld    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDXW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!vld && req[i]) begin
        vld    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// ---------------------------------------------------------------------------
// counter_sched
//   Shares one external up/down counter among NREQ requesters. A requester
//   raises req with a direction, load value and step count; the scheduler
//   grants round-robin, loads the counter, clocks it for the requested number
//   of steps and returns a one-cycle done pulse to the owner.
//
//   FSM: IDLE -> LOAD -> RUN (steps cycles) -> DONE -> IDLE
//        LOAD goes straight to DONE when steps is zero.
//   A request sampled in IDLE at cycle N completes with done at N+2+steps.
//
//   Optional feature (macro COUNTER_SCHED_STOP_ON_ZERO_EN):
//     a down-count stops early when the counter reports zero during RUN;
//     ce is withheld that cycle and done follows with aborted=1. Without the
//     macro down-counts wrap and aborted stays 0.
//
// Ports
//   clk        in  1           clock, posedge
//   rst        in  1           synchronous active-high reset
//   req        in  NREQ        per-requester level request
//   req_dir    in  NREQ        per-requester direction (1 = up)
//   req_val    in  NREQ*WIDTH  packed per-requester load values
//   req_steps  in  NREQ*WIDTH  packed per-requester step counts
//   done       out NREQ        one-cycle completion pulse to the owner
//   aborted    out 1           qualifies done: run ended early on zero
//   busy       out 1           scheduler not in IDLE
//   grant_id   out IDXW        current owner, valid while busy
//   ce         out 1           counter count enable
//   load_n     out 1           counter load strobe, active-low
//   up_down    out 1           counter direction
//   data_load  out WIDTH       counter load value
//   count_out  in  WIDTH       counter value (observed)
//   zero       in  1           counter is zero (observed)
// ---------------------------------------------------------------------------
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREQ  = DEF_NREQ,
  localparam int IDXW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_dir,
  input  logic [NREQ*WIDTH-1:0] req_val,
  input  logic [NREQ*WIDTH-1:0] req_steps,
  output logic [NREQ-1:0]       done,
  output logic                  aborted,
  output logic                  busy,
  output logic [IDXW-1:0]       grant_id,
  output logic                  ce,
  output logic                  load_n,
  output logic                  up_down,
  output logic [WIDTH-1:0]      data_load,
  input  logic [WIDTH-1:0]      count_out,
  input  logic                  zero
);

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] grant_q, grant_d;
  logic [NREQ-1:0] grant_oh_q, grant_oh_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic            aborted_q, aborted_d;
  cmd_t            cmd_q, cmd_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IDXW-1:0] arb_idx;
  logic            arb_vld;
  logic            stop_run;

  // Unpacked views of the packed per-requester command buses.
  logic [WIDTH-1:0] val_arr   [NREQ];
  logic [WIDTH-1:0] steps_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign val_arr[g]   = req_val[g*WIDTH +: WIDTH];
    assign steps_arr[g] = req_steps[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

`ifdef COUNTER_SCHED_STOP_ON_ZERO_EN
  // A down-run reaching zero ends here instead of wrapping.
  assign stop_run = (state_q == ST_RUN) && !cmd_q.dir && zero;
`else
  assign stop_run = 1'b0;
`endif

  // The counter value is observed for visibility only; the schedule itself
  // is driven by the internal step counter.
  logic unused_obs;
  assign unused_obs = ^{count_out, zero};

  // Next-state and command capture
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    rem_d      = rem_q;
    aborted_d  = aborted_q;
    cmd_d      = cmd_q;

    case (state_q)
      ST_IDLE: begin
        aborted_d = 1'b0;
        if (arb_vld) begin
          grant_d      = arb_idx;
          grant_oh_d   = arb_gnt;
          ptr_d        = IDXW'(rr_next(int'(arb_idx), NREQ));
          cmd_d.dir    = req_dir[arb_idx];
          cmd_d.val    = CMD_W'(val_arr[arb_idx]);
          cmd_d.steps  = CMD_W'(steps_arr[arb_idx]);
          state_d      = ST_LOAD;
        end
      end

      ST_LOAD: begin
        rem_d   = WIDTH'(cmd_q.steps);
        state_d = (cmd_q.steps != '0) ? ST_RUN : ST_DONE;
      end

      ST_RUN: begin
        if (stop_run) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          rem_d = rem_q - 1'b1;
          // remaining==1 marks the final ce cycle
          if (rem_q == WIDTH'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers take reset; the captured command is plain data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      grant_oh_q <= '0;
      rem_q      <= '0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      rem_q      <= rem_d;
      aborted_q  <= aborted_d;
    end
    cmd_q <= cmd_d;
  end

  // Outputs are decoded from state so reset clears them on the same edge.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    grant_id  = grant_q;
    done      = '0;
    aborted   = 1'b0;
    ce        = 1'b0;
    load_n    = 1'b1;
    up_down   = 1'b0;
    data_load = '0;

    case (state_q)
      ST_LOAD: begin
        load_n    = 1'b0;
        data_load = WIDTH'(cmd_q.val);
      end
      ST_RUN: begin
        ce      = !stop_run;
        up_down = cmd_q.dir;
      end
      ST_DONE: begin
        done    = grant_oh_q;
        aborted = aborted_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_counter_sched.sv
module tb_counter_sched;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

`ifdef COUNTER_SCHED_STOP_ON_ZERO_EN
  localparam logic [7:0] EXP34_CNT = 8'h00;
  localparam logic       EXP34_ABT = 1'b1;
  localparam int         EXP34_LAT = 5;
  localparam int         EXP34_CE  = 2;
`else
  localparam logic [7:0] EXP34_CNT = 8'hFD;
  localparam logic       EXP34_ABT = 1'b0;
  localparam int         EXP34_LAT = 7;
  localparam int         EXP34_CE  = 5;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ-1:0]       req_dir = '0;
  logic [NREQ*WIDTH-1:0] req_val = '0;
  logic [NREQ*WIDTH-1:0] req_steps = '0;
  logic [NREQ-1:0]       done;
  logic                  aborted;
  logic                  busy;
  logic [1:0]            grant_id;
  logic                  ce;
  logic                  load_n;
  logic                  up_down;
  logic [WIDTH-1:0]      data_load;
  logic [WIDTH-1:0]      count_out;
  logic                  zero;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int ce_total    = 0;

  typedef struct {
    int         id;
    logic [7:0] cnt;
    logic       abt;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ce) ce_total <= ce_total + 1;

  // Shared counter driven by the scheduler
  logic [7:0] cnt = 8'h00;
  always @(posedge clk) begin
    if (!load_n)  cnt <= data_load;
    else if (ce)  cnt <= up_down ? cnt + 8'd1 : cnt - 8'd1;
  end
  assign count_out = cnt;
  assign zero      = (cnt == 8'h00);

  counter_sched #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_dir   (req_dir),
    .req_val   (req_val),
    .req_steps (req_steps),
    .done      (done),
    .aborted   (aborted),
    .busy      (busy),
    .grant_id  (grant_id),
    .ce        (ce),
    .load_n    (load_n),
    .up_down   (up_down),
    .data_load (data_load),
    .count_out (count_out),
    .zero      (zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int id, input logic dir, input logic [7:0] val,
                         input logic [7:0] st);
    req_dir[id]          = dir;
    req_val[id*8 +: 8]   = val;
    req_steps[id*8 +: 8] = st;
  endtask

  task automatic push(input int id, input logic [7:0] c, input logic a, input int at);
    exp_t e;
    e.id  = id;
    e.cnt = c;
    e.abt = a;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (done === '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    assert (done !== '0) else begin
      miscompares++;
      $error("FAIL done_timeout observed=none expected=pulse within %0d cycles", budget);
    end
  endtask

  // Scoreboard: each done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (done !== '0) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_done observed=%b expected=none", done);
      end else begin
        mon_e = sb.pop_front();
        chk("done_onehot", 32'(done), 32'(1) << mon_e.id);
        chk("grant_id",    32'(grant_id), 32'(mon_e.id));
        chk("count_out",   32'(count_out), 32'(mon_e.cnt));
        chk("aborted",     32'(aborted), 32'(mon_e.abt));
        chk("latency",     32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int c0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_done",      32'(done), 32'd0);
    chk("rst_aborted",   32'(aborted), 32'd0);
    chk("rst_grant_id",  32'(grant_id), 32'd0);
    chk("rst_ce",        32'(ce), 32'd0);
    chk("rst_load_n",    32'(load_n), 32'd1);
    chk("rst_up_down",   32'(up_down), 32'd0);
    chk("rst_data_load", 32'(data_load), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Held 4'b1011: round-robin 0,1,3,0
    set_cmd(0, 1'b1, 8'h20, 8'd1);
    set_cmd(1, 1'b1, 8'h40, 8'd1);
    set_cmd(3, 1'b1, 8'h60, 8'd1);
    n0  = cyc;
    req = 4'b1011;
    push(0, 8'h21, 1'b0, n0 + 3);
    push(1, 8'h41, 1'b0, n0 + 7);
    push(3, 8'h61, 1'b0, n0 + 11);
    push(0, 8'h21, 1'b0, n0 + 15);
    repeat (4) wait_done(40);
    req = '0;

    // req[1] up 0x10 by 3
    @(negedge clk);
    set_cmd(1, 1'b1, 8'h10, 8'd3);
    n0  = cyc;
    c0  = ce_total;
    req = 4'b0010;
    push(1, 8'h13, 1'b0, n0 + 5);
    @(negedge clk);
    chk("load_load_n",    32'(load_n), 32'd0);
    chk("load_ce",        32'(ce), 32'd0);
    chk("load_data_load", 32'(data_load), 32'h10);
    chk("load_busy",      32'(busy), 32'd1);
    chk("load_grant_id",  32'(grant_id), 32'd1);
    @(negedge clk);
    chk("run_ce",         32'(ce), 32'd1);
    chk("run_load_n",     32'(load_n), 32'd1);
    chk("run_data_load",  32'(data_load), 32'd0);
    chk("run_up_down",    32'(up_down), 32'd1);
    wait_done(40);
    req = '0;
    chk("up3_ce_cycles",  32'(ce_total - c0), 32'd3);

    // req[2] down 0x02 by 5: stop-on-zero or wrap
    @(negedge clk);
    set_cmd(2, 1'b0, 8'h02, 8'd5);
    n0  = cyc;
    c0  = ce_total;
    req = 4'b0100;
    push(2, EXP34_CNT, EXP34_ABT, n0 + EXP34_LAT);
    wait_done(40);
    req = '0;
    chk("down5_ce_cycles", 32'(ce_total - c0), 32'(EXP34_CE));

    // req[0] up 0xFE by 3 wraps; req and command dropped mid-operation
    @(negedge clk);
    set_cmd(0, 1'b1, 8'hFE, 8'd3);
    n0  = cyc;
    req = 4'b0001;
    push(0, 8'h01, 1'b0, n0 + 5);
    @(negedge clk);
    req = '0;
    set_cmd(0, 1'b0, 8'hAA, 8'd9);
    wait_done(40);

    // steps = 0: LOAD then DONE, no ce
    @(negedge clk);
    set_cmd(3, 1'b1, 8'h55, 8'd0);
    n0  = cyc;
    c0  = ce_total;
    req = 4'b1000;
    push(3, 8'h55, 1'b0, n0 + 2);
    @(negedge clk);
    chk("zs_data_load", 32'(data_load), 32'h55);
    chk("zs_load_n",    32'(load_n), 32'd0);
    wait_done(40);
    req = '0;
    chk("zs_ce_cycles", 32'(ce_total - c0), 32'd0);

    // Reset during RUN abandons the command
    @(negedge clk);
    set_cmd(1, 1'b1, 8'h30, 8'd10);
    req = 4'b0010;
    repeat (3) @(negedge clk);
    chk("mid_run_ce", 32'(ce), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy",     32'(busy), 32'd0);
    chk("mid_rst_ce",       32'(ce), 32'd0);
    chk("mid_rst_done",     32'(done), 32'd0);
    chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
    chk("mid_rst_load_n",   32'(load_n), 32'd1);
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done", 32'(done), 32'd0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
